flex_counter_ud: RTL and testbench
==================================

Name: flex_counter_ud

Overview:
Parametrised up/down counter with programmable rollover value, synchronous load and selectable wrap or saturate behaviour. Next-generation general counter for timers, bit/byte counters and pacing logic inside lab datapaths and controllers. It keeps the existing counter's up-count rollover semantics: count 1..rollover_val, then return to 1. It adds down counting, load, saturation, a wrap pulse and an optional prescaler.

Parameters:
NUM_CNT_BITS, 4, width of count_out, rollover_val and load_val
PRESCALE_BITS, 8, width of prescale_val and the internal prescale counter; used only when FLEX_COUNTER_PRESCALE_EN is defined

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous clear, highest synchronous priority
load  input  1  synchronous load of load_val
load_val  input  NUM_CNT_BITS  value loaded when load=1
count_enable  input  1  advance request for this cycle
count_up  input  1  1 = count up, 0 = count down
saturate  input  1  1 = hold at limit, 0 = wrap
rollover_val  input  NUM_CNT_BITS  terminal (upper) count value
count_out  output  NUM_CNT_BITS  registered count
rollover_flag  output  1  registered; high while count_out == rollover_val
wrap_pulse  output  1  registered; one-cycle high in the cycle count_out shows a wrapped value

Behaviour:
- Reset (n_rst=0, asynchronous): count_out=0, rollover_flag=0, wrap_pulse=0, prescale counter=0.
- Synchronous priority, evaluated each rising edge: clear > load > step > hold.
- clear=1: count_out<=0, rollover_flag<=0, wrap_pulse<=0. Takes effect regardless of load or count_enable.
- load=1 (clear=0): count_out<=load_val, wrap_pulse<=0. Any value is legal, including 0 and values above rollover_val.
- Step occurs when count_enable=1, clear=0 and load=0 (and, with the optional feature, the prescale condition is met).
- Up step:
  - if count_out >= rollover_val: next=1 with wrap_pulse<=1 when saturate=0; next=count_out (hold) with wrap_pulse<=0 when saturate=1.
  - otherwise: next=count_out+1.
- Down step:
  - if count_out <= 1: next=rollover_val with wrap_pulse<=1 when saturate=0; next=count_out (hold) when saturate=1.
  - otherwise: next=count_out-1.
- No step: count_out holds, wrap_pulse<=0.
- rollover_flag<=(next_count == rollover_val) every cycle except clear. It follows a changed rollover_val one cycle later even while holding.
- Latency: one cycle from input to count_out/flags. There is no combinational input-to-output path.
- rollover_val=0: up step always yields 1 (wrap_pulse each step, non-saturate); down wrap yields 0. Outputs are defined, but this is not a supported operating point.
- Direction change mid-count takes effect on the next step with no extra latency.
- Reset mid-operation overrides everything immediately (asynchronous).

Optional Feature:
FLEX_COUNTER_PRESCALE_EN
- Defined:
  - Adds input prescale_val [PRESCALE_BITS-1:0].
  - An internal prescale counter increments on each enabled cycle.
  - The main counter steps only on the enabled cycle where the prescale counter == prescale_val; the prescale counter then returns to 0.
  - prescale_val=0 means step every enabled cycle.
  - clear and load zero the prescale counter.
  - When count_enable=0, the prescale counter holds.
- Not defined: no prescale_val port and no prescale logic; the counter steps on every enabled cycle.

Test Plan:
- Up wrap: reset, rollover_val=5, count_up=1, saturate=0, enable 7 cycles -> count_out 1,2,3,4,5,1,2. rollover_flag high only while count_out=5. wrap_pulse high only with the second 1.
- Down wrap/saturate: load_val=3 then count_up=0, enable 4 cycles with saturate=0 -> 2,1,5,4 (wrap_pulse with 5). Repeat with saturate=1 -> 2,1,1,1, wrap_pulse never high.
- Priority: clear=1, load=1, count_enable=1 at count_out=4 -> count_out=0, flags 0. Next cycle load=1, load_val=9, rollover_val=9 -> count_out=9, rollover_flag=1.
- Out-of-range load: rollover_val=5, load_val=12, up step -> count_out=1 with wrap_pulse=1. Same load with saturate=1 -> holds 12.
- Async reset: assert n_rst mid-count (count_out=3, between clock edges) -> outputs 0 immediately. Release -> first enabled up step gives count_out=1.
- With FLEX_COUNTER_PRESCALE_EN, prescale_val=2, rollover_val=3: 9 enabled cycles -> count_out steps every 3rd cycle: 1,2,3. Disabling for 2 cycles mid-way delays the next step by exactly 2 cycles.

Source files
------------

// File: rtl/flex_counter_ud_if.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter_ud_if
// Description : Control/status bundle for the flex_counter_ud up/down
//               counter. The master side drives the control inputs and
//               reads the registered count and flags. The slave side is
//               the counter itself.
// Signals     : clear, load, load_val, count_enable, count_up, saturate,
//               rollover_val (master -> slave); count_out, rollover_flag,
//               wrap_pulse (slave -> master); prescale_val (master -> slave,
//               present only when FLEX_COUNTER_PRESCALE_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
interface flex_counter_ud_if #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 8
);
  logic                     clear;
  logic                     load;
  logic [NUM_CNT_BITS-1:0]  load_val;
  logic                     count_enable;
  logic                     count_up;
  logic                     saturate;
  logic [NUM_CNT_BITS-1:0]  rollover_val;
  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     rollover_flag;
  logic                     wrap_pulse;
`ifdef FLEX_COUNTER_PRESCALE_EN
  logic [PRESCALE_BITS-1:0] prescale_val;

  modport master (
    output clear, load, load_val, count_enable, count_up, saturate,
           rollover_val, prescale_val,
    input  count_out, rollover_flag, wrap_pulse
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_up, saturate,
           rollover_val, prescale_val,
    output count_out, rollover_flag, wrap_pulse
  );
`else
  modport master (
    output clear, load, load_val, count_enable, count_up, saturate,
           rollover_val,
    input  count_out, rollover_flag, wrap_pulse
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_up, saturate,
           rollover_val,
    output count_out, rollover_flag, wrap_pulse
  );
`endif
endinterface
`default_nettype wire

// File: rtl/flex_counter_ud.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter_ud
// Description : Parametrised up/down counter with programmable rollover
//               value, synchronous clear/load and selectable wrap or
//               saturate behaviour. Counting range is 1..rollover_val.
//               A registered wrap_pulse marks the cycle a wrapped value
//               appears on count_out.
// Options     : FLEX_COUNTER_PRESCALE_EN - adds prescale_val and an internal
//               prescale counter; the main counter then steps only once
//               every (prescale_val+1) enabled cycles.
// Ports       : clk   - system clock, rising edge
//               n_rst - asynchronous active-low reset
//               bus   - flex_counter_ud_if slave modport (controls, count,
//                       rollover_flag, wrap_pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter_ud #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  flex_counter_ud_if.slave  bus
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count;
  logic                    rollover_flag;
  logic                    wrap_pulse;

  logic [NUM_CNT_BITS-1:0] next_count;
  logic                    next_wrap;
  logic                    step;

`ifdef FLEX_COUNTER_PRESCALE_EN
  logic [PRESCALE_BITS-1:0] prescale_cnt;
  logic                     prescale_hit;

  assign prescale_hit = (prescale_cnt == bus.prescale_val);
  assign step         = bus.count_enable & prescale_hit;

  // Prescale counter advances only on enabled cycles and restarts after
  // each hit; clear and load realign it so the next step is a full period away.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prescale_cnt <= '0;
    end else if (bus.clear || bus.load) begin
      prescale_cnt <= '0;
    end else if (bus.count_enable) begin
      if (prescale_hit) begin
        prescale_cnt <= '0;
      end else begin
        prescale_cnt <= prescale_cnt + 1'b1;
      end
    end
  end
`else
  assign step = bus.count_enable;
`endif

  // Next-count selection for load / step / hold. Clear is handled in the
  // register because it also forces rollover_flag low.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (bus.load) begin
      next_count = bus.load_val;
    end else if (step) begin
      if (bus.count_up) begin
        // ">=" so an out-of-range loaded value wraps/saturates instead of
        // counting up through the top of the register.
        if (count >= bus.rollover_val) begin
          if (!bus.saturate) begin
            next_count = CNT_ONE;
            next_wrap  = 1'b1;
          end
        end else begin
          next_count = count + CNT_ONE;
        end
      end else begin
        // Zero is treated like 1 so a down step never underflows.
        if (count <= CNT_ONE) begin
          if (!bus.saturate) begin
            next_count = bus.rollover_val;
            next_wrap  = 1'b1;
          end
        end else begin
          next_count = count - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count         <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else if (bus.clear) begin
      count         <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else begin
      count         <= next_count;
      // Recomputed every cycle so a changed rollover_val is reflected even
      // while the count holds.
      rollover_flag <= (next_count == bus.rollover_val);
      wrap_pulse    <= next_wrap;
    end
  end

  assign bus.count_out     = count;
  assign bus.rollover_flag = rollover_flag;
  assign bus.wrap_pulse    = wrap_pulse;

endmodule
`default_nettype wire

// File: tb/tb_flex_counter_ud.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_counter_ud
// Description : Self-checking bench for flex_counter_ud. Directed vector
//               table, randomized traffic against a behavioural model, and
//               hand-written asynchronous reset / prescale sequences.
//               FLEX_COUNTER_PRESCALE_EN selects the prescale variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_counter_ud;

  localparam int W  = 4;
  localparam int PW = 8;

  logic clk;
  logic n_rst;

  flex_counter_ud_if #(.NUM_CNT_BITS(W), .PRESCALE_BITS(PW)) cif ();

  flex_counter_ud #(.NUM_CNT_BITS(W), .PRESCALE_BITS(PW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Behavioural reference state
  int m_cnt, m_flag, m_wrap, m_psc;

  typedef struct {
    logic         clr, ld;
    logic [W-1:0] lv;
    logic         en, up, sat;
    logic [W-1:0] rv;
    logic [W-1:0] ecnt;
    logic         ef, ew;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int clr, ld, lv, en, up, sat, rv,
                              ecnt, ef, ew);
    vec_t v;
    v.clr = clr[0]; v.ld = ld[0]; v.lv = W'(lv);
    v.en = en[0]; v.up = up[0]; v.sat = sat[0]; v.rv = W'(rv);
    v.ecnt = W'(ecnt); v.ef = ef[0]; v.ew = ew[0];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    cif.clear        = v.clr;
    cif.load         = v.ld;
    cif.load_val     = v.lv;
    cif.count_enable = v.en;
    cif.count_up     = v.up;
    cif.saturate     = v.sat;
    cif.rollover_val = v.rv;
  endtask

  // Reference model: one clock of the counter from the rules, plain integers.
  task automatic model_step();
    int lim, stepping;
    lim = int'(cif.rollover_val);
    if (cif.clear) begin
      m_cnt = 0; m_flag = 0; m_wrap = 0; m_psc = 0;
      return;
    end
    if (cif.load) begin
      m_cnt = int'(cif.load_val); m_wrap = 0; m_psc = 0;
    end else begin
      stepping = int'(cif.count_enable);
`ifdef FLEX_COUNTER_PRESCALE_EN
      if (cif.count_enable) begin
        if (m_psc == int'(cif.prescale_val)) m_psc = 0;
        else begin
          m_psc = (m_psc + 1) % (1 << PW);
          stepping = 0;
        end
      end
`endif
      m_wrap = 0;
      if (stepping != 0) begin
        if (cif.count_up) begin
          if (m_cnt < lim) m_cnt = m_cnt + 1;
          else if (!cif.saturate) begin m_cnt = 1; m_wrap = 1; end
        end else begin
          if (m_cnt > 1) m_cnt = m_cnt - 1;
          else if (!cif.saturate) begin m_cnt = lim; m_wrap = 1; end
        end
      end
    end
    m_flag = (m_cnt == lim) ? 1 : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, int'(cif.count_out), m_cnt);
    check({tag, ".flag"},  int'(cif.rollover_flag), m_flag);
    check({tag, ".wrap"},  int'(cif.wrap_pulse), m_wrap);
  endtask

  initial begin
    vec_t v;
    // Directed table: rows are {clr,ld,lv,en,up,sat,rv, cnt,flag,wrap}
    // up wrap, rollover 5
    tbl.push_back(mk(0,0,0,1,1,0,5, 1,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,5, 2,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,5, 3,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,5, 4,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,5, 5,1,0));
    tbl.push_back(mk(0,0,0,1,1,0,5, 1,0,1));
    tbl.push_back(mk(0,0,0,1,1,0,5, 2,0,0));
    // down wrap from 3
    tbl.push_back(mk(0,1,3,0,0,0,5, 3,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,5, 2,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,5, 1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,5, 5,1,1));
    tbl.push_back(mk(0,0,0,1,0,0,5, 4,0,0));
    // down saturate from 3
    tbl.push_back(mk(0,1,3,0,0,1,5, 3,0,0));
    tbl.push_back(mk(0,0,0,1,0,1,5, 2,0,0));
    tbl.push_back(mk(0,0,0,1,0,1,5, 1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1,5, 1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1,5, 1,0,0));
    // priority: clear beats load and enable
    tbl.push_back(mk(0,1,4,0,1,0,5, 4,0,0));
    tbl.push_back(mk(1,1,4,1,1,0,5, 0,0,0));
    tbl.push_back(mk(0,1,9,0,1,0,9, 9,1,0));
    // out-of-range load, wrap then saturate
    tbl.push_back(mk(0,1,12,0,1,0,5, 12,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,5, 1,0,1));
    tbl.push_back(mk(0,1,12,0,1,1,5, 12,0,0));
    tbl.push_back(mk(0,0,0,1,1,1,5, 12,0,0));
    // rollover_val change while holding raises the flag
    tbl.push_back(mk(0,0,0,0,1,1,12, 12,1,0));
    // rollover_val = 0 corner
    tbl.push_back(mk(0,0,0,1,1,0,0, 1,0,1));
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,1,1));

    n_rst = 1'b0;
    v = mk(0,0,0,0,1,0,5, 0,0,0);
    drive(v);
`ifdef FLEX_COUNTER_PRESCALE_EN
    cif.prescale_val = '0;
`endif
    m_cnt = 0; m_flag = 0; m_wrap = 0; m_psc = 0;
    #12;
    check("reset.count", int'(cif.count_out), 0);
    check("reset.flag",  int'(cif.rollover_flag), 0);
    check("reset.wrap",  int'(cif.wrap_pulse), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      check($sformatf("vec%0d.count", i), int'(cif.count_out), int'(tbl[i].ecnt));
      check($sformatf("vec%0d.flag", i),  int'(cif.rollover_flag), int'(tbl[i].ef));
      check($sformatf("vec%0d.wrap", i),  int'(cif.wrap_pulse), int'(tbl[i].ew));
    end

    // Asynchronous reset in the middle of a cycle
    drive(mk(0,1,3,0,1,0,5, 0,0,0));
    tick();
    check("prearst.count", int'(cif.count_out), 3);
    drive(mk(0,0,0,1,1,0,5, 0,0,0));
    #3;
    n_rst = 1'b0;
    #1;
    check("arst.count", int'(cif.count_out), 0);
    check("arst.flag",  int'(cif.rollover_flag), 0);
    check("arst.wrap",  int'(cif.wrap_pulse), 0);
    @(negedge clk);
    n_rst = 1'b1;
    m_cnt = 0; m_flag = 0; m_wrap = 0; m_psc = 0;
    tick();
    check("postarst.count", int'(cif.count_out), 1);

`ifdef FLEX_COUNTER_PRESCALE_EN
    begin
      int exp_a[9] = '{0,0,1,1,1,2,2,2,3};
      int en_b[6]  = '{1,1,0,0,1,1};
      int exp_b[6] = '{0,0,0,0,1,1};
      drive(mk(1,0,0,0,1,0,3, 0,0,0));
      tick();
      cif.prescale_val = PW'(2);
      drive(mk(0,0,0,1,1,0,3, 0,0,0));
      for (int i = 0; i < 9; i++) begin
        tick();
        check($sformatf("psc%0d.count", i), int'(cif.count_out), exp_a[i]);
      end
      drive(mk(1,0,0,0,1,0,3, 0,0,0));
      tick();
      for (int i = 0; i < 6; i++) begin
        drive(mk(0,0,0,en_b[i],1,0,3, 0,0,0));
        tick();
        check($sformatf("pscgap%0d.count", i), int'(cif.count_out), exp_b[i]);
      end
      cif.prescale_val = PW'(1);
    end
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      v.clr = ($urandom_range(0, 19) == 0);
      v.ld  = ($urandom_range(0, 9) == 0);
      v.lv  = W'($urandom);
      v.en  = ($urandom_range(0, 3) != 0);
      v.up  = ($urandom_range(0, 3) != 0);
      v.sat = ($urandom_range(0, 4) == 0);
      v.rv  = (i % 50 < 25) ? W'($urandom_range(1, 6)) : W'($urandom);
      drive(v);
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
